// File: rtl/common.sv
// Shared thread-control types and vectors: thread id, PC type, thread count, boot/exception entry.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package common;

    localparam int n_threads = 8;
    localparam int TID_W     = $clog2(n_threads);

    typedef logic [TID_W-1:0] threadid_t;
    typedef logic [31:0]      vptr_t;

    localparam vptr_t BOOT_VECTOR = 32'h0000_1000;
    localparam vptr_t EXC_VECTOR  = 32'h0000_2000;

    // Sequential fetch advance; wraps naturally at 2^32.
    function automatic vptr_t pc_next(input vptr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/thread_arbiter.sv
// Picks the first requesting thread, searching upward from i_ptr and wrapping at N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
module thread_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [$clog2(N)-1:0] o_grant,
    output logic                 o_valid
);

    localparam int TW = $clog2(N);

    logic [TW-1:0] w_idx;

    // Rotating search; N is a power of two, so the index add wraps for free.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = i_ptr + TW'(k);
            if (!o_valid && i_req[w_idx]) begin
                o_valid = 1'b1;
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/thread_ctrl.sv
// Per-thread PC/stall/privilege/exception context plus fetch thread selection.
// Latency: fetch offer is combinational from registered state; updates land next cycle.
// Backpressure: thread PC only advances when fetch_valid && fetch_ready. Macro THREAD_RR_EN
// selects round-robin selection; undefined gives fixed lowest-index priority.
module thread_ctrl
    import common::*;
#(
    parameter int    N_THREADS = 8,
    parameter vptr_t BOOT_PC   = BOOT_VECTOR,
    parameter vptr_t EXC_PC    = EXC_VECTOR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic [$clog2(N_THREADS)-1:0] fetch_thread,
    output logic [31:0]                  fetch_pc,
    input  logic [N_THREADS-1:0]         stall_set,
    input  logic [N_THREADS-1:0]         stall_clr,
    output logic [N_THREADS-1:0]         stalled,
    input  logic [N_THREADS-1:0]         wb_pc_en,
    input  logic [31:0]                  wb_pc_data,
    input  logic                         exc_en,
    input  logic [$clog2(N_THREADS)-1:0] exc_thread,
    input  logic [31:0]                  exc_pc,
    input  logic [31:0]                  exc_cause,
    input  logic                         iret_en,
    input  logic [$clog2(N_THREADS)-1:0] iret_thread,
    output logic [N_THREADS-1:0]         mode,
    output logic [N_THREADS*32-1:0]      rm0,
    output logic [N_THREADS*32-1:0]      rm2
);

    localparam int TW = $clog2(N_THREADS);

    vptr_t                r_pc  [N_THREADS];
    vptr_t                r_rm0 [N_THREADS];
    vptr_t                r_rm2 [N_THREADS];
    logic [N_THREADS-1:0] r_stalled;
    logic [N_THREADS-1:0] r_mode;
    logic [TW-1:0]        r_last_thread;
    vptr_t                r_last_pc;

    logic [TW-1:0]        w_ptr;
    logic [TW-1:0]        w_grant;
    logic                 w_valid;
    logic                 w_accept;
    logic [N_THREADS-1:0] w_exc_hit;
    logic [N_THREADS-1:0] w_iret_hit;

`ifdef THREAD_RR_EN
    logic [TW-1:0] r_ptr;

    // Round-robin pointer moves just past the thread that was actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_grant + TW'(1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    thread_arbiter #(.N(N_THREADS)) u_arb (
        .i_req   (~r_stalled),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_accept     = w_valid && fetch_ready;
    assign fetch_valid  = w_valid;
    assign fetch_thread = w_valid ? w_grant : r_last_thread;
    assign fetch_pc     = w_valid ? r_pc[w_grant] : r_last_pc;
    assign stalled      = r_stalled;
    assign mode         = r_mode;

    // Decode exception/iret targets; an exception on a thread swallows its iret.
    always_comb begin
        w_exc_hit  = '0;
        w_iret_hit = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            w_exc_hit[t]  = exc_en && (exc_thread == TW'(t));
            w_iret_hit[t] = iret_en && (iret_thread == TW'(t)) && !w_exc_hit[t];
        end
    end

    // Flatten saved exception context onto the output buses.
    always_comb begin
        rm0 = '0;
        rm2 = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            rm0[t*32 +: 32] = r_rm0[t];
            rm2[t*32 +: 32] = r_rm2[t];
        end
    end

    // Hold the last offer so fetch outputs stay stable while every thread is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_thread <= '0;
            r_last_pc     <= BOOT_PC;
        end else if (w_valid) begin
            r_last_thread <= w_grant;
            r_last_pc     <= r_pc[w_grant];
        end
    end

    // Per-thread state: exception > iret > wb redirect > fetch increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_THREADS; t++) begin
                r_pc[t]  <= BOOT_PC;
                r_rm0[t] <= '0;
                r_rm2[t] <= '0;
            end
            r_stalled <= '0;
            r_mode    <= '1;
        end else begin
            for (int t = 0; t < N_THREADS; t++) begin
                if (w_exc_hit[t]) begin
                    r_pc[t]      <= EXC_PC;
                    r_rm0[t]     <= exc_pc;
                    r_rm2[t]     <= exc_cause;
                    r_mode[t]    <= 1'b1;
                    r_stalled[t] <= 1'b0;
                end else begin
                    if (w_iret_hit[t]) begin
                        r_pc[t]   <= r_rm0[t];
                        r_mode[t] <= 1'b0;
                    end else if (wb_pc_en[t]) begin
                        r_pc[t] <= wb_pc_data;
                    end else if (w_accept && (w_grant == TW'(t))) begin
                        r_pc[t] <= pc_next(r_pc[t]);
                    end
                    // Set dominates clr, so a same-cycle pair leaves the thread stalled.
                    if (stall_set[t]) begin
                        r_stalled[t] <= 1'b1;
                    end else if (stall_clr[t]) begin
                        r_stalled[t] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_thread_ctrl.sv
// Self-checking bench for thread_ctrl: reset, stall table, directed corner sequences, random vs model.
// Latency: checks fetch outputs each cycle, one cycle after inputs are applied.
// Backpressure: fetch_ready driven both directed and random.
module tb_thread_ctrl;
    import common::*;

    localparam int N = 8;

`ifdef THREAD_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [2:0]    fetch_thread;
    logic [31:0]   fetch_pc;
    logic [N-1:0]  stall_set, stall_clr, stalled, wb_pc_en, mode;
    logic [31:0]   wb_pc_data, exc_pc, exc_cause;
    logic          exc_en, iret_en;
    logic [2:0]    exc_thread, iret_thread;
    logic [N*32-1:0] rm0, rm2;

    always #5 clk = ~clk;

    thread_ctrl #(.N_THREADS(N), .BOOT_PC(32'h1000), .EXC_PC(32'h2000)) dut (
        .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_thread(fetch_thread), .fetch_pc(fetch_pc), .stall_set(stall_set),
        .stall_clr(stall_clr), .stalled(stalled), .wb_pc_en(wb_pc_en), .wb_pc_data(wb_pc_data),
        .exc_en(exc_en), .exc_thread(exc_thread), .exc_pc(exc_pc), .exc_cause(exc_cause),
        .iret_en(iret_en), .iret_thread(iret_thread), .mode(mode), .rm0(rm0), .rm2(rm2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain per-thread arrays driven by the behavioural rules.
    int unsigned m_pc [N];
    int unsigned m_rm0[N];
    int unsigned m_rm2[N];
    bit          m_st [N];
    bit          m_mode[N];
    int          m_ptr;
    int          m_last_t;
    int unsigned m_last_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pc[i] = 32'h1000; m_rm0[i] = 0; m_rm2[i] = 0; m_st[i] = 0; m_mode[i] = 1;
        end
        m_ptr = 0; m_last_t = 0; m_last_pc = 32'h1000;
    endtask

    task automatic model_sel(output bit v, output int s);
        int j;
        v = 0; s = 0;
        for (int k = 0; k < N; k++) begin
            j = RR ? (m_ptr + k) % N : k;
            if (!v && !m_st[j]) begin v = 1; s = j; end
        end
    endtask

    task automatic model_step();
        bit v, acc, e, r;
        int s;
        int unsigned offered_pc;
        model_sel(v, s);
        acc = v && fetch_ready;
        offered_pc = m_pc[s];
        for (int t = 0; t < N; t++) begin
            e = exc_en && (int'(exc_thread) == t);
            r = iret_en && (int'(iret_thread) == t) && !e;
            if (e) begin
                m_pc[t] = 32'h2000; m_rm0[t] = exc_pc; m_rm2[t] = exc_cause;
                m_mode[t] = 1; m_st[t] = 0;
            end else begin
                if (r) begin m_pc[t] = m_rm0[t]; m_mode[t] = 0; end
                else if (wb_pc_en[t]) m_pc[t] = wb_pc_data;
                else if (acc && s == t) m_pc[t] = m_pc[t] + 4;
                if (stall_set[t]) m_st[t] = 1;
                else if (stall_clr[t]) m_st[t] = 0;
            end
        end
        if (v) begin m_last_t = s; m_last_pc = offered_pc; end
        if (RR && acc) m_ptr = (s + 1) % N;
    endtask

    task automatic model_check();
        bit v;
        int s;
        logic [N-1:0] exp_st, exp_mode;
        model_sel(v, s);
        chk("rnd_valid", fetch_valid, v);
        chk("rnd_thread", fetch_thread, v ? s : m_last_t);
        chk("rnd_pc", fetch_pc, v ? m_pc[s] : m_last_pc);
        for (int i = 0; i < N; i++) begin
            exp_st[i] = m_st[i]; exp_mode[i] = m_mode[i];
            chk("rnd_rm0", rm0[i*32 +: 32], m_rm0[i]);
            chk("rnd_rm2", rm2[i*32 +: 32], m_rm2[i]);
        end
        chk("rnd_stalled", stalled, exp_st);
        chk("rnd_mode", mode, exp_mode);
    endtask

    task automatic clear_inputs();
        fetch_ready = 0; stall_set = '0; stall_clr = '0; wb_pc_en = '0; wb_pc_data = '0;
        exc_en = 0; exc_thread = '0; exc_pc = '0; exc_cause = '0; iret_en = 0; iret_thread = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Reset with junk on every input to show reset dominates.
    task automatic do_reset();
        clear_inputs();
        rst = 1; fetch_ready = 1; stall_set = '1; wb_pc_en = '1; wb_pc_data = 32'hBAD0;
        exc_en = 1; exc_thread = 3'd3; exc_pc = 32'hBAD1; iret_en = 1; iret_thread = 3'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        clear_inputs();
        rst = 0;
    endtask

    typedef struct {
        logic [N-1:0] set;
        logic [N-1:0] clr;
        logic [N-1:0] exp_st;
        logic         exp_v;
        int           exp_t;
    } vec_t;

    vec_t tbl[8];
    bit   found;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst = 1;
        do_reset();

        // Reset state
        chk("rst_valid", fetch_valid, 1);
        chk("rst_thread", fetch_thread, 0);
        chk("rst_pc", fetch_pc, 32'h1000);
        chk("rst_stalled", stalled, 8'h00);
        chk("rst_mode", mode, 8'hFF);
        chk("rst_rm0_3", rm0[3*32 +: 32], 0);
        chk("rst_rm2_3", rm2[3*32 +: 32], 0);

        // Stall table, fetch_ready low so no PC moves and the pointer stays at 0
        tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b1, 0};
        tbl[1] = '{8'h01, 8'h00, 8'h01, 1'b1, 1};
        tbl[2] = '{8'h02, 8'h02, 8'h03, 1'b1, 2};
        tbl[3] = '{8'h01, 8'h00, 8'h03, 1'b1, 2};
        tbl[4] = '{8'h00, 8'h04, 8'h03, 1'b1, 2};
        tbl[5] = '{8'hFC, 8'h00, 8'hFF, 1'b0, 2};
        tbl[6] = '{8'h00, 8'h80, 8'h7F, 1'b1, 7};
        tbl[7] = '{8'h00, 8'h7F, 8'h00, 1'b1, 0};
        for (int i = 0; i < 8; i++) begin
            stall_set = tbl[i].set; stall_clr = tbl[i].clr;
            tick();
            stall_set = '0; stall_clr = '0;
            chk("tbl_stalled", stalled, tbl[i].exp_st);
            chk("tbl_valid", fetch_valid, tbl[i].exp_v);
            chk("tbl_thread", fetch_thread, tbl[i].exp_t);
            chk("tbl_pc", fetch_pc, 32'h1000);
        end

        // Continuous fetch for 10 cycles
        do_reset();
        fetch_ready = 1;
        for (int i = 0; i < 10; i++) begin
            chk("seq_thread", fetch_thread, RR ? i % 8 : 0);
            chk("seq_pc", fetch_pc, RR ? 32'h1000 + 4 * (i / 8) : 32'h1000 + 4 * i);
            tick();
        end
        fetch_ready = 0;

        // Stall skip and release
        do_reset();
        fetch_ready = 1;
        if (RR) begin
            stall_set = 8'h04;
            chk("skip_t0", fetch_thread, 0);
            tick();
            stall_set = '0;
            chk("skip_t1", fetch_thread, 1);
            tick();
            chk("skip_t3", fetch_thread, 3);
            chk("skip_stalled", stalled, 8'h04);
            stall_clr = 8'h04;
            tick();
            stall_clr = '0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && fetch_valid && fetch_thread == 3'd2) begin
                    found = 1;
                    chk("release_pc", fetch_pc, 32'h1000);
                end
                tick();
            end
            chk("release_offered", found, 1);
        end else begin
            chk("fixed_t0", fetch_thread, 0);
            stall_set = 8'h01;
            tick();
            stall_set = '0;
            chk("fixed_t1", fetch_thread, 1);
            tick();
            chk("fixed_t1_again", fetch_thread, 1);
        end
        fetch_ready = 0;

        // Exception with same-cycle redirect, then iret, then exc+iret collision
        do_reset();
        stall_set = 8'hF7;
        tick();
        stall_set = '0;
        chk("exc_pre_thread", fetch_thread, 3);
        exc_en = 1; exc_thread = 3'd3; exc_pc = 32'h1234; exc_cause = 32'd5;
        wb_pc_en = 8'h08; wb_pc_data = 32'hDEAD0000;
        tick();
        clear_inputs();
        chk("exc_pc3", fetch_pc, 32'h2000);
        chk("exc_rm0_3", rm0[3*32 +: 32], 32'h1234);
        chk("exc_rm2_3", rm2[3*32 +: 32], 32'd5);
        chk("exc_mode3", mode[3], 1);
        iret_en = 1; iret_thread = 3'd3;
        tick();
        clear_inputs();
        chk("iret_pc3", fetch_pc, 32'h1234);
        chk("iret_mode3", mode[3], 0);
        chk("iret_rm0_3", rm0[3*32 +: 32], 32'h1234);
        exc_en = 1; exc_thread = 3'd3; exc_pc = 32'h5678; exc_cause = 32'd9;
        iret_en = 1; iret_thread = 3'd3;
        tick();
        clear_inputs();
        chk("collide_pc3", fetch_pc, 32'h2000);
        chk("collide_mode3", mode[3], 1);
        chk("collide_rm0_3", rm0[3*32 +: 32], 32'h5678);
        exc_en = 1; exc_thread = 3'd0; exc_pc = 32'h40; exc_cause = 32'd1;
        tick();
        clear_inputs();
        chk("exc_unstall0", stalled, 8'hF6);
        chk("exc_t0_offered", fetch_thread, 0);
        chk("exc_t0_pc", fetch_pc, 32'h2000);

        // PC wrap, then all-stalled hold
        do_reset();
        stall_set = 8'hFE; wb_pc_en = 8'h01; wb_pc_data = 32'hFFFFFFFC;
        tick();
        clear_inputs();
        chk("wrap_pre", fetch_pc, 32'hFFFFFFFC);
        fetch_ready = 1;
        tick();
        fetch_ready = 0;
        chk("wrap_pc", fetch_pc, 32'h0);
        stall_set = 8'h01;
        tick();
        stall_set = '0;
        chk("allst_valid", fetch_valid, 0);
        chk("allst_thread", fetch_thread, 0);
        chk("allst_pc", fetch_pc, 32'h0);
        fetch_ready = 1;
        tick();
        fetch_ready = 0;
        chk("allst_hold_valid", fetch_valid, 0);
        chk("allst_hold_pc", fetch_pc, 32'h0);
        stall_clr = 8'h10;
        tick();
        stall_clr = '0;
        chk("allst_release_t4", fetch_thread, 4);
        chk("allst_release_pc", fetch_pc, 32'h1000);

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            fetch_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                stall_set[i] = ($urandom_range(0, 9) == 0);
                stall_clr[i] = ($urandom_range(0, 2) == 0);
                wb_pc_en[i]  = ($urandom_range(0, 15) == 0);
            end
            wb_pc_data  = $urandom;
            exc_en      = ($urandom_range(0, 11) == 0);
            exc_thread  = 3'($urandom_range(0, N - 1));
            exc_pc      = $urandom;
            exc_cause   = $urandom;
            iret_en     = ($urandom_range(0, 9) == 0);
            iret_thread = 3'($urandom_range(0, N - 1));
            model_check();
            tick();
        end
        clear_inputs();
        model_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
